pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Control FSM that sequences the program counter and register-file write of the primitive programmable device.
- Decodes the current 32-bit instruction word and drives PC enable / PC operation select, register-file write enable and the write-source select.
- Stalls on external-input instructions via a valid/ready handshake.
- Supports free-run and single-step modes and a sticky halt.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.
- PC_W, 8, PC / branch-offset width (offset field is instr[12:5] when 8).

Ports:
- CLK  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- instr  in  32  instruction at current PC (combinational instruction memory). Fields:
  - [31] B, conditional branch.
  - [30] C, unconditional jump.
  - [29:28] WS, write source.
  - [12:5] offset.
- flag  in  1  ALU comparison result for the current instruction.
- run_mode  in  1  1 = free-run, 0 = single-step.
- step  in  1  step request, level; rising edge detected internally.
- in_valid  in  1  external input data available.
- in_ready  out  1  sequencer accepts external input this cycle.
- pc_en  out  1  PC advances at next CLK edge.
- pc_op  out  1  0 = PC+1, 1 = PC+offset.
- rf_we  out  1  register-file write enable.
- ws  out  2  registered-through copy of instr[29:28] (combinational).
- halted  out  1  FSM in HALT.
- state  out  3  FSM state code, for debug/LEDs.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- Reset (rst=1 at edge):
  - state=PAUSE, retired=0, step_q=0.
  - All combinational outputs evaluate to 0 in PAUSE.
  - rst dominates every other input.
- States: PAUSE=0, EXEC=1, WAIT_IN=2, HALT=3. Codes 4-7 unused; they recover to PAUSE.
- Decode in EXEC:
  - halt_i = B & C.
  - br_i = B ^ C.
  - in_i = !B & !C & (WS==2'b01).
  - alu_i = otherwise.
- step_rise = step & !step_q; step_q <= step every cycle.
- PAUSE:
  - All of pc_en, rf_we, in_ready, pc_op are 0.
  - Next state EXEC if run_mode=1 or step_rise=1, else PAUSE.
- EXEC with halt_i:
  - pc_en=0, rf_we=0; next state HALT.
  - Retired not incremented.
- EXEC with br_i:
  - pc_en=1, rf_we=0.
  - pc_op = C | (B & flag).
- EXEC with alu_i:
  - pc_en=1, pc_op=0, rf_we=1.
- EXEC with in_i:
  - in_ready=1.
  - If in_valid=1: transfer this cycle; pc_en=1, pc_op=0, rf_we=1.
  - Else: pc_en=0, rf_we=0; next state WAIT_IN.
- WAIT_IN:
  - in_ready=1, pc_op=0.
  - On in_valid=1: pc_en=1, rf_we=1.
  - Otherwise all outputs 0; stay.
- Completion rule:
  - Every cycle with pc_en=1 completes one instruction.
  - retired <= retired+1, wrapping at 2^CNT_W.
  - Next state: EXEC if run_mode=1, else PAUSE.
  - run_mode is sampled in the completing cycle only.
- HALT:
  - All control outputs 0, halted=1.
  - Sticky until rst; step and run_mode are ignored.
- Handshake: in_ready never depends on in_valid.
- in_valid held high in PAUSE/HALT: no effect, no transfer.
- Single instruction per step: a held step level causes exactly one instruction.
- ws output always equals instr[29:28]; it is meaningful only when rf_we=1.
- Latency:
  - Free-run non-stalled: one instruction per cycle.
  - First instruction completes in the 2nd cycle after rst deasserts.
- rst asserted while in WAIT_IN: no transfer that cycle; returns to PAUSE.

Test Plan:
- Free-run ALU program: rst 1 cycle, run_mode=1, instr=ALU ops (B=C=0, WS=00) → cycle1 PAUSE, then pc_en=1, rf_we=1, pc_op=0 each cycle; retired=5 after 6 cycles.
- Branches: instr B=1, offset=8'hFC:
  - flag=1 → pc_op=1, rf_we=0.
  - flag=0 → pc_op=0.
  - C=1, flag=0 → pc_op=1.
- Input handshake: WS=01, in_valid low 4 cycles then high 1 cycle → EXEC→WAIT_IN, in_ready=1 throughout, pc_en/rf_we=0 until transfer cycle, then pc_en=rf_we=1 for exactly 1 cycle; in_valid already high in EXEC → transfer same cycle, no WAIT_IN.
- Single-step: run_mode=0, step held high 10 cycles → exactly one pc_en pulse, retired+1; second rising edge → one more.
- Halt: instr B=C=1 → state HALT, halted=1, pc_en=0, retired frozen; toggling step/run_mode has no effect; rst returns to PAUSE with retired=0.
- Reset mid-stall: rst=1 while WAIT_IN with in_valid=1 → no rf_we/pc_en that cycle; state=PAUSE, retired=0 next cycle.

Source files
------------

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
// Control FSM that sequences the program counter and register-file write of
// the primitive programmable device. It decodes the instruction at the
// current PC and drives the PC enable/operation, the register-file write
// enable and the write-source select. External-input instructions stall on
// a valid/ready handshake. The FSM supports free-run and single-step modes
// and a sticky halt.
//
// Ports:
//   CLK       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   instr     in   [31:0] instruction at current PC
//                  [31]=B branch, [30]=C jump, [29:28]=WS, [12:5]=offset
//   flag      in   ALU comparison result for the current instruction
//   run_mode  in   1 = free-run, 0 = single-step
//   step      in   step request (level; rising edge used)
//   in_valid  in   external input data available
//   in_ready  out  sequencer accepts external input this cycle
//   pc_en     out  PC advances at next CLK edge
//   pc_op     out  0 = PC+1, 1 = PC+offset
//   rf_we     out  register-file write enable
//   ws        out  [1:0] copy of instr[29:28]
//   halted    out  FSM in HALT
//   state     out  [2:0] FSM state code
//   retired   out  [CNT_W-1:0] completed-instruction count
// ---------------------------------------------------------------------------
module pc_sequencer #(
    parameter int CNT_W = 16,
    parameter int PC_W  = 8
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             flag,
    input  logic             run_mode,
    input  logic             step,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             pc_en,
    output logic             pc_op,
    output logic             rf_we,
    output logic [1:0]       ws,
    output logic             halted,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    localparam logic [2:0] ST_PAUSE   = 3'd0;
    localparam logic [2:0] ST_EXEC    = 3'd1;
    localparam logic [2:0] ST_WAIT_IN = 3'd2;
    localparam logic [2:0] ST_HALT    = 3'd3;

    // Reduction parity, used to fold the fields this block does not consume.
    function automatic logic parity32(input logic [31:0] v);
        return ^v;
    endfunction

    logic [2:0]       state_r;
    logic [2:0]       next_state_s;
    logic [CNT_W-1:0] retired_r;
    logic             step_q_r;
    logic             step_rise_s;

    logic             b_s;
    logic             c_s;
    logic             halt_i_s;
    logic             br_i_s;
    logic             in_i_s;

    logic             in_ready_s;
    logic             pc_en_s;
    logic             pc_op_s;
    logic             rf_we_s;

    // The branch offset is consumed by the PC datapath, not by this FSM.
    logic [PC_W-1:0]  offset_unused_s;
    logic             fields_unused_s;

    assign offset_unused_s = instr[5 +: PC_W];
    assign fields_unused_s = parity32({instr[27:0], 4'b0000});

    assign b_s         = instr[31];
    assign c_s         = instr[30];
    assign halt_i_s    = b_s & c_s;
    assign br_i_s      = b_s ^ c_s;
    assign in_i_s      = ~b_s & ~c_s & (instr[29:28] == 2'b01);
    assign step_rise_s = step & ~step_q_r;

    // Output decode and next-state selection; rst forces every control low.
    always_comb begin
        in_ready_s   = 1'b0;
        pc_en_s      = 1'b0;
        pc_op_s      = 1'b0;
        rf_we_s      = 1'b0;
        next_state_s = state_r;
        if (rst) begin
            next_state_s = ST_PAUSE;
        end else begin
            case (state_r)
                ST_PAUSE: begin
                    if (run_mode || step_rise_s) begin
                        next_state_s = ST_EXEC;
                    end else begin
                        next_state_s = ST_PAUSE;
                    end
                end
                ST_EXEC: begin
                    if (halt_i_s) begin
                        next_state_s = ST_HALT;
                    end else if (br_i_s) begin
                        pc_en_s = 1'b1;
                        pc_op_s = c_s | (b_s & flag);
                    end else if (in_i_s) begin
                        // in_ready is decided before in_valid is looked at.
                        in_ready_s = 1'b1;
                        if (in_valid) begin
                            pc_en_s = 1'b1;
                            rf_we_s = 1'b1;
                        end else begin
                            next_state_s = ST_WAIT_IN;
                        end
                    end else begin
                        pc_en_s = 1'b1;
                        rf_we_s = 1'b1;
                    end
                end
                ST_WAIT_IN: begin
                    in_ready_s = 1'b1;
                    if (in_valid) begin
                        pc_en_s = 1'b1;
                        rf_we_s = 1'b1;
                    end else begin
                        next_state_s = ST_WAIT_IN;
                    end
                end
                ST_HALT: begin
                    next_state_s = ST_HALT;
                end
                default: begin
                    next_state_s = ST_PAUSE;
                end
            endcase
            // A completing instruction picks the next state from run_mode.
            if (pc_en_s) begin
                next_state_s = run_mode ? ST_EXEC : ST_PAUSE;
            end else begin
                next_state_s = next_state_s;
            end
        end
    end

    // State, step edge history and retired counter.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state_r   <= ST_PAUSE;
            retired_r <= {CNT_W{1'b0}};
            step_q_r  <= 1'b0;
        end else begin
            state_r  <= next_state_s;
            step_q_r <= step;
            if (pc_en_s) begin
                retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign in_ready = in_ready_s;
    assign pc_en    = pc_en_s;
    assign pc_op    = pc_op_s;
    assign rf_we    = rf_we_s;
    assign ws       = instr[29:28];
    assign halted   = (state_r == ST_HALT);
    assign state    = state_r;
    assign retired  = retired_r;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    logic        CLK;
    logic        rst;
    logic [31:0] instr;
    logic        flag;
    logic        run_mode;
    logic        step;
    logic        in_valid;
    logic        in_ready;
    logic        pc_en;
    logic        pc_op;
    logic        rf_we;
    logic [1:0]  ws;
    logic        halted;
    logic [2:0]  state;
    logic [15:0] retired;

    localparam logic [31:0] I_ALU  = 32'h0000_0000;
    localparam logic [31:0] I_ALW2 = 32'h2000_0000;
    localparam logic [31:0] I_INP  = 32'h1000_0000;
    localparam logic [31:0] I_BR   = 32'h8000_1F80;
    localparam logic [31:0] I_JMP  = 32'h4000_1F80;
    localparam logic [31:0] I_HLT  = 32'hC000_0000;

    pc_sequencer #(.CNT_W(16), .PC_W(8)) dut (
        .CLK(CLK), .rst(rst), .instr(instr), .flag(flag),
        .run_mode(run_mode), .step(step), .in_valid(in_valid),
        .in_ready(in_ready), .pc_en(pc_en), .pc_op(pc_op), .rf_we(rf_we),
        .ws(ws), .halted(halted), .state(state), .retired(retired)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic [31:0] instr;
        logic        flag;
        logic        run;
        logic        step;
        logic        valid;
        logic        e_rdy;
        logic        e_en;
        logic        e_op;
        logic        e_we;
        logic [1:0]  e_ws;
        logic        e_halt;
        logic [2:0]  e_state;
        logic [15:0] e_ret;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [31:0] ins, input logic f,
                       input logic rm, input logic st, input logic v,
                       input logic rdy, input logic en, input logic op,
                       input logic we, input logic [1:0] w, input logic h,
                       input logic [2:0] s, input logic [15:0] ret);
        vec_t x;
        x.rst = r; x.instr = ins; x.flag = f; x.run = rm; x.step = st; x.valid = v;
        x.e_rdy = rdy; x.e_en = en; x.e_op = op; x.e_we = we; x.e_ws = w;
        x.e_halt = h; x.e_state = s; x.e_ret = ret;
        vecs.push_back(x);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int pulses;
        int waited;
        logic [15:0] ret_at_halt;

        rst = 1'b1; instr = I_ALU; flag = 1'b0; run_mode = 1'b0;
        step = 1'b0; in_valid = 1'b0;
        tick();

        //  rst ins    f    run  stp  vld  rdy  en   op   we   ws     hlt  st    ret
        add(1, I_ALU,  0,   1,   0,   0,   0,   0,   0,   0,   2'd0,  0,   3'd0, 16'd0);
        add(0, I_ALU,  0,   1,   0,   0,   0,   0,   0,   0,   2'd0,  0,   3'd0, 16'd0);
        add(0, I_ALU,  0,   1,   0,   0,   0,   1,   0,   1,   2'd0,  0,   3'd1, 16'd0);
        add(0, I_ALW2, 0,   1,   0,   0,   0,   1,   0,   1,   2'd2,  0,   3'd1, 16'd1);
        add(0, I_ALU,  0,   1,   0,   0,   0,   1,   0,   1,   2'd0,  0,   3'd1, 16'd2);
        add(0, I_ALU,  0,   1,   0,   0,   0,   1,   0,   1,   2'd0,  0,   3'd1, 16'd3);
        add(0, I_ALU,  0,   1,   0,   0,   0,   1,   0,   1,   2'd0,  0,   3'd1, 16'd4);
        add(0, I_BR,   1,   1,   0,   0,   0,   1,   1,   0,   2'd0,  0,   3'd1, 16'd5);
        add(0, I_BR,   0,   1,   0,   0,   0,   1,   0,   0,   2'd0,  0,   3'd1, 16'd6);
        add(0, I_JMP,  0,   1,   0,   0,   0,   1,   1,   0,   2'd0,  0,   3'd1, 16'd7);
        add(0, I_INP,  0,   1,   0,   1,   1,   1,   0,   1,   2'd1,  0,   3'd1, 16'd8);
        add(0, I_INP,  0,   1,   0,   0,   1,   0,   0,   0,   2'd1,  0,   3'd1, 16'd9);
        add(0, I_INP,  0,   1,   0,   0,   1,   0,   0,   0,   2'd1,  0,   3'd2, 16'd9);
        add(0, I_INP,  0,   1,   0,   0,   1,   0,   0,   0,   2'd1,  0,   3'd2, 16'd9);
        add(0, I_INP,  0,   1,   0,   0,   1,   0,   0,   0,   2'd1,  0,   3'd2, 16'd9);
        add(0, I_INP,  0,   1,   0,   1,   1,   1,   0,   1,   2'd1,  0,   3'd2, 16'd9);
        add(0, I_ALU,  0,   0,   0,   0,   0,   1,   0,   1,   2'd0,  0,   3'd1, 16'd10);
        add(0, I_ALU,  0,   0,   0,   0,   0,   0,   0,   0,   2'd0,  0,   3'd0, 16'd11);
        add(0, I_ALU,  0,   0,   1,   0,   0,   0,   0,   0,   2'd0,  0,   3'd0, 16'd11);
        add(0, I_ALU,  0,   0,   1,   0,   0,   1,   0,   1,   2'd0,  0,   3'd1, 16'd11);
        add(0, I_ALU,  0,   0,   1,   0,   0,   0,   0,   0,   2'd0,  0,   3'd0, 16'd12);
        add(0, I_ALU,  0,   0,   1,   0,   0,   0,   0,   0,   2'd0,  0,   3'd0, 16'd12);
        add(0, I_INP,  0,   0,   1,   1,   0,   0,   0,   0,   2'd1,  0,   3'd0, 16'd12);
        add(0, I_ALU,  0,   0,   0,   0,   0,   0,   0,   0,   2'd0,  0,   3'd0, 16'd12);
        add(0, I_ALU,  0,   0,   1,   0,   0,   0,   0,   0,   2'd0,  0,   3'd0, 16'd12);
        add(0, I_ALU,  0,   0,   1,   0,   0,   1,   0,   1,   2'd0,  0,   3'd1, 16'd12);
        add(0, I_ALU,  0,   1,   0,   0,   0,   0,   0,   0,   2'd0,  0,   3'd0, 16'd13);
        add(0, I_HLT,  0,   1,   0,   0,   0,   0,   0,   0,   2'd0,  0,   3'd1, 16'd13);
        add(0, I_ALU,  0,   0,   1,   0,   0,   0,   0,   0,   2'd0,  1,   3'd3, 16'd13);
        add(0, I_INP,  0,   1,   0,   1,   0,   0,   0,   0,   2'd1,  1,   3'd3, 16'd13);
        add(0, I_ALU,  0,   1,   1,   0,   0,   0,   0,   0,   2'd0,  1,   3'd3, 16'd13);
        add(1, I_ALU,  0,   1,   1,   0,   0,   0,   0,   0,   2'd0,  1,   3'd3, 16'd13);
        add(0, I_ALU,  0,   0,   0,   0,   0,   0,   0,   0,   2'd0,  0,   3'd0, 16'd0);
        add(0, I_INP,  0,   1,   0,   0,   0,   0,   0,   0,   2'd1,  0,   3'd0, 16'd0);
        add(0, I_INP,  0,   1,   0,   0,   1,   0,   0,   0,   2'd1,  0,   3'd1, 16'd0);
        add(0, I_INP,  0,   1,   0,   0,   1,   0,   0,   0,   2'd1,  0,   3'd2, 16'd0);
        add(1, I_INP,  0,   1,   0,   1,   0,   0,   0,   0,   2'd1,  0,   3'd2, 16'd0);
        add(0, I_INP,  0,   0,   0,   1,   0,   0,   0,   0,   2'd1,  0,   3'd0, 16'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; instr = vecs[i].instr; flag = vecs[i].flag;
            run_mode = vecs[i].run; step = vecs[i].step; in_valid = vecs[i].valid;
            #2;
            check($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].e_rdy});
            check($sformatf("v%0d_pc_en", i),    {31'd0, pc_en},    {31'd0, vecs[i].e_en});
            check($sformatf("v%0d_pc_op", i),    {31'd0, pc_op},    {31'd0, vecs[i].e_op});
            check($sformatf("v%0d_rf_we", i),    {31'd0, rf_we},    {31'd0, vecs[i].e_we});
            check($sformatf("v%0d_ws", i),       {30'd0, ws},       {30'd0, vecs[i].e_ws});
            check($sformatf("v%0d_halted", i),   {31'd0, halted},   {31'd0, vecs[i].e_halt});
            check($sformatf("v%0d_state", i),    {29'd0, state},    {29'd0, vecs[i].e_state});
            check($sformatf("v%0d_retired", i),  {16'd0, retired},  {16'd0, vecs[i].e_ret});
            tick();
        end

        // Held step level: one instruction per rising edge only.
        rst = 1'b0; instr = I_ALU; run_mode = 1'b0; in_valid = 1'b0; step = 1'b0;
        tick();
        pulses = 0;
        step = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #2;
            if (pc_en) pulses++;
            tick();
        end
        check("step_held_pulses", pulses, 32'd1);
        check("step_held_retired", {16'd0, retired}, 32'd1);
        step = 1'b0;
        tick();
        step = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #2;
            if (pc_en) pulses++;
            tick();
        end
        check("step_second_pulses", pulses, 32'd2);
        check("step_second_retired", {16'd0, retired}, 32'd2);

        // Halt is sticky: poke step/run_mode/in_valid and confirm nothing moves.
        step = 1'b0; run_mode = 1'b1; instr = I_HLT;
        waited = 0;
        while (!halted && waited < 6) begin
            tick();
            waited++;
        end
        check("halt_reached", {31'd0, halted}, 32'd1);
        ret_at_halt = retired;
        check("halt_retired", {16'd0, ret_at_halt}, 32'd2);
        for (int i = 0; i < 8; i++) begin
            step = i[0]; run_mode = i[1]; in_valid = i[2];
            instr = i[0] ? I_ALU : I_INP;
            #2;
            if (pc_en || rf_we || in_ready || !halted || state != 3'd3 || retired != ret_at_halt) begin
                check($sformatf("halt_sticky_%0d", i),
                      {pc_en, rf_we, in_ready, halted, state, retired},
                      {1'b0, 1'b0, 1'b0, 1'b1, 3'd3, ret_at_halt});
            end else begin
                n_checks++;
            end
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0; run_mode = 1'b0; step = 1'b0; in_valid = 1'b0;
        #2;
        check("halt_rst_state", {29'd0, state}, 32'd0);
        check("halt_rst_retired", {16'd0, retired}, 32'd0);
        check("halt_rst_halted", {31'd0, halted}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
